// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding for the bit-serial arithmetic blocks
package arith_pkg;

    // FSM encoding; the unused code 2'd3 is treated as IDLE by the decoders
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_add.sv
// rtl/full_add.sv - single-bit combinational full adder cell
module full_add (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_p;

    // Propagate term shared by sum and carry; carry written in the same
    // generate/propagate form as the subtractor's borrow cell
    always_comb begin
        w_p    = i_a ^ i_b;
        o_sum  = w_p ^ i_cin;
        o_cout = (i_a & i_b) | (i_cin & w_p);
    end

endmodule

// File: rtl/serial_carry_adder.sv
// rtl/serial_carry_adder.sv - bit-serial adder, LSB first, one full-adder cell
module serial_carry_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_load;
    logic             w_step;

    // The only adder cell: works on the current LSBs and the stored carry
    full_add u_full_add (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_c),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    assign w_load = i_in_valid & o_in_ready;
    assign w_step = (r_state == ST_RUN);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: RUN ends after the bit with cnt == WIDTH-1
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:  if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
            ST_DONE: if (i_out_ready)       w_next_state = ST_IDLE;
            default: if (i_in_valid)        w_next_state = ST_RUN;
        endcase
    end

    // Outputs decoded from state; in_ready and out_valid are mutually exclusive
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ST_RUN:  o_busy      = 1'b1;
            ST_DONE: o_out_valid = 1'b1;
            default: o_in_ready  = 1'b1;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN cycle;
    // result and final carry are left untouched until the next load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_sum <= '0;
            r_c   <= i_cin;
            r_cnt <= '0;
        end else if (w_step) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= {w_s, r_sum[WIDTH-1:1]};
            r_c   <= w_c;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_c;

endmodule

// File: tb/tb_serial_carry_adder.sv
// tb/tb_serial_carry_adder.sv - self-checking bench for serial_carry_adder
module tb_serial_carry_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_cin = 1'b0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b1;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_busy;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;

    logic [W:0] exp_q[$];
    int         age_q[$];

    serial_carry_adder #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_cin       (i_cin),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // out_ready driver: 0 = held low, 1 = held high, 2 = random each cycle
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       i_out_ready = 1'b0;
            1:       i_out_ready = 1'b1;
            default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: each accepted transaction is due a+b+cin, is busy for
    // W cycles after accept and presents its result from cycle W+1 on
    always @(negedge clk) begin
        if (i_rst) begin
            check("rst_in_ready", o_in_ready, 1);
            check("rst_out_valid", o_out_valid, 0);
            check("rst_busy", o_busy, 0);
            check("rst_sum", o_sum, 0);
            check("rst_cout", o_cout, 0);
            exp_q.delete();
            age_q.delete();
        end else begin
            logic exp_valid, exp_busy, exp_ready;
            if (age_q.size() > 0) age_q[0] = age_q[0] + 1;
            exp_ready = (age_q.size() == 0);
            exp_busy  = (age_q.size() > 0) && (age_q[0] >= 1) && (age_q[0] <= W);
            exp_valid = (age_q.size() > 0) && (age_q[0] >= W + 1);
            check("in_ready", o_in_ready, exp_ready);
            check("busy", o_busy, exp_busy);
            check("out_valid", o_out_valid, exp_valid);
            if (o_out_valid && exp_valid) begin
                check("result", {o_cout, o_sum}, exp_q[0]);
                if (i_out_ready) begin
                    void'(exp_q.pop_front());
                    void'(age_q.pop_front());
                end
            end
            if (i_in_valid && o_in_ready && exp_ready) begin
                exp_q.push_back((W+1)'(i_a) + (W+1)'(i_b) + (W+1)'(i_cin));
                age_q.push_back(0);
            end
        end
    end

    // Offer operands when ready; lat counts clocks from accept edge (inclusive) to out_valid
    task automatic start_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int lat);
        int n = 0;
        lat = 0;
        while (!o_in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!o_in_ready) timeout("in_ready_wait");
        i_a = a; i_b = b; i_cin = c; i_in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 i_in_valid = 1'b0;
        while (!o_out_valid && lat < 50) begin
            @(posedge clk); lat++; #1;
        end
        if (!o_out_valid) timeout("out_valid_wait");
    endtask

    task automatic wait_done();
        int n = 0;
        while (o_out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (o_out_valid) timeout("out_handshake_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] s0;
        logic c0;

        repeat (3) @(posedge clk);
        #1;
        check("init_sum", o_sum, 0);
        check("init_in_ready", o_in_ready, 1);
        i_rst = 1'b0;
        @(posedge clk); #1;

        start_txn(8'h5A, 8'h3C, 1'b0, lat);
        check("lat_5a3c", lat, W + 1);
        check("sum_5a3c", {o_cout, o_sum}, 9'h096);
        wait_done();

        start_txn(8'hFF, 8'h01, 1'b0, lat);
        check("sum_ff01", {o_cout, o_sum}, 9'h100);
        wait_done();

        start_txn(8'hFF, 8'h00, 1'b1, lat);
        check("sum_ff00c", {o_cout, o_sum}, 9'h100);
        wait_done();
        start_txn(8'h00, 8'h00, 1'b0, lat);
        check("sum_0000", {o_cout, o_sum}, 9'h000);
        wait_done();

        // Backpressure: result held, in_valid ignored while DONE
        rdy_mode = 0;
        start_txn(8'hA7, 8'h6B, 1'b1, lat);
        s0 = o_sum;
        c0 = o_cout;
        check("bp_value", {c0, s0}, 9'h113);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1;
            i_a = W'($urandom);
            i_b = W'($urandom);
            check("bp_sum", o_sum, s0);
            check("bp_cout", o_cout, c0);
            check("bp_out_valid", o_out_valid, 1);
            check("bp_in_ready", o_in_ready, 0);
        end
        i_in_valid = 1'b0;
        rdy_mode = 1;
        @(posedge clk); #1;
        check("bp_release_in_ready", o_in_ready, 1);
        check("bp_release_out_valid", o_out_valid, 0);

        // Reset in the middle of RUN at cnt == 3
        i_a = 8'h12; i_b = 8'h34; i_cin = 1'b0; i_in_valid = 1'b1;
        @(posedge clk); #1 i_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_busy", o_busy, 1);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_in_ready", o_in_ready, 1);
        check("mid_rst_sum", o_sum, 0);
        check("mid_rst_cout", o_cout, 0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", o_out_valid, 0);
        end
        start_txn(8'h12, 8'h34, 1'b0, lat);
        check("sum_1234", {o_cout, o_sum}, 9'h046);
        wait_done();

        // Random sweep with random out_ready and idle gaps
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            start_txn(ra, rb, rc, lat);
            check("rnd_lat", lat, W + 1);
            wait_done();
        end
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
